regfile_wb_ctrl: RTL and testbench

//  Write-back controller: the producer side of the register file write interface.

---
 rtl/regfile_wb_pkg.sv | 37 +++
 rtl/wb_hilo_fifo.sv | 102 ++++++++++
 rtl/regfile_wb_ctrl.sv | 124 ++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_pkg
// Description : Shared definitions for the register-file write-back path.
//               Word/address widths, the HI/LO GPR aliases and the {hi,lo}
//               result record are used by the regfile, decode, the mul/div
//               unit and the write-back controller.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int HI_REG = 31;
    localparam int LO_REG = 30;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_t;

    // Occupancy state of the HI:LO result queue.
    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } q_state_t;

    // True when a GPR write targets one of the HI/LO aliases.
    function automatic logic is_hilo_addr(input logic [ADDR_W-1:0] addr);
        return (addr == ADDR_W'(HI_REG)) || (addr == ADDR_W'(LO_REG));
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_hilo_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_hilo_fifo
// Description : Synchronous FIFO of hilo_t records holding mul/div results
//               waiting for the regfile HI/LO port.
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : enqueue din (ignored when full)
//   pop        : dequeue head (ignored when empty)
//   head       : oldest entry (valid when !empty)
//   full/empty : registered occupancy flags
//   count      : number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module wb_hilo_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2    // power of two, >= 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  hilo_t                  din,
    input  logic                   pop,
    output hilo_t                  head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    hilo_t           r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    q_state_t        r_state;

    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_nxt;

    assign full  = (r_state == Q_FULL);
    assign empty = (r_state == Q_EMPTY);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_comb begin
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= Q_EMPTY;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            unique case (r_state)
                Q_EMPTY: begin
                    if (w_push) begin
                        r_state <= Q_PARTIAL;
                    end
                end
                Q_PARTIAL: begin
                    if (w_count_nxt == C_DEPTH) begin
                        r_state <= Q_FULL;
                    end else if (w_count_nxt == '0) begin
                        r_state <= Q_EMPTY;
                    end
                end
                Q_FULL: begin
                    if (w_pop && !w_push) begin
                        r_state <= Q_PARTIAL;
                    end
                end
                default: r_state <= Q_EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_ctrl
// Description : Write-back controller feeding the regfile. Merges ALU results
//               onto the GPR write port and queued mul/div HI:LO results onto
//               the HI/LO port, holds the flags value and reports pending
//               HI/LO writes so decode can stall.
//   alu_*      : ALU result valid/ready handshake, address, data
//   flags_*    : flags update strobe and value
//   md_*       : mul/div HI:LO result valid/ready handshake
//   rf_*       : registered regfile write ports and flags value
//   hilo_busy_o: a HI/LO write is queued, offered or issuing
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl
    import regfile_wb_pkg::*;
#(
    parameter int MQ_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [ADDR_W-1:0] alu_waddr_i,
    input  logic [DATA_W-1:0] alu_wdata_i,
    input  logic              flags_valid_i,
    input  logic [DATA_W-1:0] flags_i,
    input  logic              md_valid_i,
    output logic              md_ready_o,
    input  logic [DATA_W-1:0] md_hi_i,
    input  logic [DATA_W-1:0] md_lo_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              rf_mul_we_o,
    output logic [DATA_W-1:0] rf_hi_o,
    output logic [DATA_W-1:0] rf_lo_o,
    output logic [DATA_W-1:0] rf_flags_o,
    output logic              hilo_busy_o
);

    localparam int WW = $clog2(STARVE_MAX + 1);
    localparam logic [WW-1:0] C_STARVE_MAX = WW'(STARVE_MAX);

    logic [WW-1:0]             r_wait_cnt;
    logic                      w_alu_fire;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic [$clog2(MQ_DEPTH):0] w_count;
    hilo_t                     w_head;
    hilo_t                     w_din;

    // Ready is forced low while in reset and whenever the queued head has
    // been starved long enough; that idle ALU cycle guarantees the pop.
    assign alu_ready_o = !rst && (r_wait_cnt != C_STARVE_MAX);
    assign md_ready_o  = !rst && !w_full;

    assign w_alu_fire = alu_valid_i && alu_ready_o;
    assign w_push     = md_valid_i && md_ready_o;

    // The head only yields to an ALU write aimed at the HI/LO aliases so the
    // two ports never update the same architectural register together.
    assign w_pop = !w_empty && !(w_alu_fire && is_hilo_addr(alu_waddr_i));

    assign w_din.hi = md_hi_i;
    assign w_din.lo = md_lo_i;

    assign hilo_busy_o = (w_count != '0) || md_valid_i || rf_mul_we_o;

    wb_hilo_fifo #(
        .DEPTH (MQ_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_din),
        .pop   (w_pop),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt  <= '0;
            rf_we_o     <= 1'b0;
            rf_waddr_o  <= '0;
            rf_wdata_o  <= ZERO_WORD;
            rf_mul_we_o <= 1'b0;
            rf_hi_o     <= ZERO_WORD;
            rf_lo_o     <= ZERO_WORD;
            rf_flags_o  <= ZERO_WORD;
        end else begin
            // r0 writes complete the handshake but never reach the regfile.
            rf_we_o <= w_alu_fire && (alu_waddr_i != '0);
            if (w_alu_fire) begin
                rf_waddr_o <= alu_waddr_i;
                rf_wdata_o <= alu_wdata_i;
            end

            rf_mul_we_o <= w_pop;
            if (w_pop) begin
                rf_hi_o <= w_head.hi;
                rf_lo_o <= w_head.lo;
            end

            if (w_pop) begin
                r_wait_cnt <= '0;
            end else if (!w_empty && (r_wait_cnt != C_STARVE_MAX)) begin
                r_wait_cnt <= r_wait_cnt + WW'(1);
            end

            if (flags_valid_i) begin
                rf_flags_o <= flags_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_ctrl
// Description : Self-checking bench for regfile_wb_ctrl. A driver issues
//               directed and random traffic and pushes expected regfile writes
//               into scoreboard queues; a monitor pops and compares them
//               whenever the DUT presents a write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_ctrl;
    import regfile_wb_pkg::*;

    localparam int MQ_DEPTH   = 2;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alu_valid_i = 1'b0;
    logic              alu_ready_o;
    logic [ADDR_W-1:0] alu_waddr_i = '0;
    logic [DATA_W-1:0] alu_wdata_i = '0;
    logic              flags_valid_i = 1'b0;
    logic [DATA_W-1:0] flags_i = '0;
    logic              md_valid_i = 1'b0;
    logic              md_ready_o;
    logic [DATA_W-1:0] md_hi_i = '0;
    logic [DATA_W-1:0] md_lo_i = '0;
    logic              rf_we_o;
    logic [ADDR_W-1:0] rf_waddr_o;
    logic [DATA_W-1:0] rf_wdata_o;
    logic              rf_mul_we_o;
    logic [DATA_W-1:0] rf_hi_o;
    logic [DATA_W-1:0] rf_lo_o;
    logic [DATA_W-1:0] rf_flags_o;
    logic              hilo_busy_o;

    regfile_wb_ctrl #(
        .MQ_DEPTH   (MQ_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid_i   (alu_valid_i),
        .alu_ready_o   (alu_ready_o),
        .alu_waddr_i   (alu_waddr_i),
        .alu_wdata_i   (alu_wdata_i),
        .flags_valid_i (flags_valid_i),
        .flags_i       (flags_i),
        .md_valid_i    (md_valid_i),
        .md_ready_o    (md_ready_o),
        .md_hi_i       (md_hi_i),
        .md_lo_i       (md_lo_i),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .rf_mul_we_o   (rf_mul_we_o),
        .rf_hi_o       (rf_hi_o),
        .rf_lo_o       (rf_lo_o),
        .rf_flags_o    (rf_flags_o),
        .hilo_busy_o   (hilo_busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct { int due; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } gpr_exp_t;
    typedef struct { int due; logic [DATA_W-1:0] hi; logic [DATA_W-1:0] lo; } mul_exp_t;

    gpr_exp_t          gq[$];        // expected GPR writes
    mul_exp_t          mq[$];        // expected HI/LO writes
    logic [63:0]       m_q[$];       // reference HI:LO queue contents
    int                m_wait = 0;   // cycles the reference head has waited
    bit                m_mul_prev = 1'b0;
    logic [DATA_W-1:0] m_flags = '0;
    logic [DATA_W-1:0] flags_at[int];
    bit                rst_at[int];
    int                starve_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus plus the reference model's view of that cycle.
    task automatic step(input logic r, input logic av, input logic [ADDR_W-1:0] aa,
                        input logic [DATA_W-1:0] ad, input logic fv, input logic [DATA_W-1:0] f,
                        input logic mv, input logic [DATA_W-1:0] h, input logic [DATA_W-1:0] l,
                        output bit afire, output bit mfire);
        bit          exp_ar;
        bit          exp_mr;
        bit          popm;
        logic [63:0] hd;
        afire = 1'b0;
        mfire = 1'b0;
        @(posedge clk);
        #1;
        rst = r; alu_valid_i = av; alu_waddr_i = aa; alu_wdata_i = ad;
        flags_valid_i = fv; flags_i = f; md_valid_i = mv; md_hi_i = h; md_lo_i = l;
        #1;
        if (r) begin
            chk("alu_ready_in_rst", alu_ready_o, 0);
            chk("md_ready_in_rst", md_ready_o, 0);
            m_q.delete();
            m_wait     = 0;
            m_mul_prev = 1'b0;
            m_flags    = '0;
            flags_at[cyc+1] = '0;
            rst_at[cyc+1]   = 1'b1;
            return;
        end
        exp_ar = (m_wait != STARVE_MAX);
        exp_mr = (m_q.size() < MQ_DEPTH);
        if (!exp_ar) starve_seen++;
        chk("alu_ready", alu_ready_o, exp_ar);
        chk("md_ready", md_ready_o, exp_mr);
        chk("hilo_busy", hilo_busy_o, (m_q.size() != 0) || mv || m_mul_prev);
        afire = av && exp_ar;
        mfire = mv && exp_mr;
        if (afire && aa != 0) gq.push_back('{cyc + 1, aa, ad});
        popm = (m_q.size() != 0) && !(afire && (aa == HI_REG || aa == LO_REG));
        if (popm) begin
            hd = m_q.pop_front();
            mq.push_back('{cyc + 1, hd[63:32], hd[31:0]});
            m_wait = 0;
        end else if (m_q.size() != 0 && m_wait < STARVE_MAX) begin
            m_wait++;
        end
        if (mfire) m_q.push_back({h, l});
        m_mul_prev = popm;
        if (fv) m_flags = f;
        flags_at[cyc+1] = m_flags;
    endtask

    task automatic idle(input int n);
        bit a, m;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, a, m);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    initial begin
        int c;
        gpr_exp_t g;
        mul_exp_t m;
        forever begin
            @(negedge clk);
            c = cyc;
            if (flags_at.exists(c)) begin
                chk("rf_flags", rf_flags_o, flags_at[c]);
                if (rst_at.exists(c)) begin
                    chk("rst_rf_waddr", rf_waddr_o, 0);
                    chk("rst_rf_wdata", rf_wdata_o, 0);
                    chk("rst_rf_hi", rf_hi_o, 0);
                    chk("rst_rf_lo", rf_lo_o, 0);
                end
                if (gq.size() != 0 && gq[0].due == c) begin
                    g = gq.pop_front();
                    chk("rf_we", rf_we_o, 1);
                    chk("rf_waddr", rf_waddr_o, g.a);
                    chk("rf_wdata", rf_wdata_o, g.d);
                end else begin
                    chk("rf_we_idle", rf_we_o, 0);
                end
                if (mq.size() != 0 && mq[0].due == c) begin
                    m = mq.pop_front();
                    chk("rf_mul_we", rf_mul_we_o, 1);
                    chk("rf_hi", rf_hi_o, m.hi);
                    chk("rf_lo", rf_lo_o, m.lo);
                end else begin
                    chk("rf_mul_we_idle", rf_mul_we_o, 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit a, m;
        int k;
        // Reset
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, a, m);
        // Single ALU write, then an r0 write that is accepted and dropped
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, a, m);
        idle(1);
        step(0, 1, 5'd0, 32'h1234, 0, 0, 0, 0, 0, a, m);
        idle(2);
        // Lone HI:LO result, two-cycle latency
        step(0, 0, 0, 0, 0, 0, 1, 32'h1, 32'h2, a, m);
        idle(3);
        // Three results against continuous ALU writes to r31: fills, starves, drains
        k = 0;
        for (int i = 0; i < 14; i++) begin
            step(0, 1, 5'd31, 32'h100 + i, 0, 0, k < 3, 32'hA0 + k, 32'hB0 + k, a, m);
            if (m) k++;
        end
        idle(4);
        // ALU write to r7 in the same cycle as a HI/LO pop
        step(0, 0, 0, 0, 0, 0, 1, 32'h11, 32'h22, a, m);
        step(0, 1, 5'd7, 32'h77, 0, 0, 0, 0, 0, a, m);
        idle(2);
        // Flags hold, then reset with two entries queued
        step(0, 0, 0, 0, 1, 32'hA, 0, 0, 0, a, m);
        idle(3);
        step(0, 1, 5'd30, 32'h1, 0, 0, 1, 32'hC1, 32'hD1, a, m);
        step(0, 1, 5'd31, 32'h2, 0, 0, 1, 32'hC2, 32'hD2, a, m);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, a, m);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, a, m);
        idle(4);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [ADDR_W-1:0] ra;
            int sel;
            sel = int'($urandom_range(0, 9));
            ra  = (sel < 3) ? 5'd31 : (sel < 5) ? 5'd30 : (sel == 5) ? 5'd0 : ADDR_W'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, ra, $urandom,
                 $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 9) < 4,
                 $urandom, $urandom, a, m);
        end
        idle(10);
        @(negedge clk);
        @(negedge clk);
        chk("gpr_scoreboard_drained", gq.size(), 0);
        chk("hilo_scoreboard_drained", mq.size(), 0);
        chk("starvation_observed", starve_seen != 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
